// File: rtl/shreg_ctrl.sv
// Arbitrates two requesters onto an external 4-bit shift register and frames its LSB-first serial output.
// Define SHREG_CTRL_RR_EN for round-robin tie-breaking; the default build uses fixed priority to requester 0.
module shreg_ctrl #(
    parameter int unsigned GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] data0,
    input  logic [3:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [3:0] sreg_d,
    output logic       sreg_en,
    input  logic       sreg_q0,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_id,
    output logic       done,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [1:0] GAP_LAST = (GAP == 0) ? 2'd0 : 2'(GAP - 1);

    state_t     state_q;
    logic [1:0] cnt_q;
    logic       win_q;
    logic       win_d;
    logic       gnt0_q;
    logic       gnt1_q;
    logic [3:0] sreg_d_q;
    logic       sreg_en_q;
    logic       ser_valid_q;
    logic       ser_id_q;
    logic       done_q;
    logic       busy_q;
`ifdef SHREG_CTRL_RR_EN
    logic       ptr_q;
`endif

    // Winner among the current requests; a lone requester always wins.
    always_comb begin
        win_d = 1'b0;
`ifdef SHREG_CTRL_RR_EN
        if (req0 && req1) begin
            win_d = ptr_q;
        end else begin
            win_d = req1;
        end
`else
        win_d = !req0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            win_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            sreg_d_q    <= 4'd0;
            sreg_en_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_id_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SHREG_CTRL_RR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            sreg_en_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        state_q   <= S_LOAD;
                        win_q     <= win_d;
                        gnt0_q    <= !win_d;
                        gnt1_q    <= win_d;
                        sreg_d_q  <= win_d ? data1 : data0;
                        sreg_en_q <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef SHREG_CTRL_RR_EN
                        ptr_q     <= !win_d;
`endif
                    end
                end
                S_LOAD: begin
                    state_q     <= S_SHIFT;
                    cnt_q       <= 2'd0;
                    ser_valid_q <= 1'b1;
                    ser_id_q    <= win_q;
                end
                S_SHIFT: begin
                    // done is registered, so it is raised on the way into the last bit.
                    if (cnt_q == 2'd3) begin
                        ser_valid_q <= 1'b0;
                        ser_id_q    <= 1'b0;
                        cnt_q       <= 2'd0;
                        if (GAP == 0) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else begin
                        cnt_q  <= cnt_q + 2'd1;
                        done_q <= (cnt_q == 2'd2);
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= 2'd0;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign sreg_d    = sreg_d_q;
    assign sreg_en   = sreg_en_q;
    assign ser_valid = ser_valid_q;
    assign ser_id    = ser_id_q;
    assign done      = done_q;
    assign busy      = busy_q;
    // The shift register already presents the current bit; only gate it to zero between frames.
    assign ser_out   = ser_valid_q & sreg_q0;

endmodule
